// File: rtl/pixel_frame_buffer.sv
// Frame buffer: one registered read port, one read-modify-write port,
// and a fill engine that sweeps the whole frame, including after reset.
module pixel_frame_buffer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int COLOR_BITS   = 1,
  parameter int X_BITS       = 10,
  parameter int Y_BITS       = 10,
  parameter int ADDR_BITS    = 19
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  readEn,
  input  logic [X_BITS-1:0]     readX,
  input  logic [Y_BITS-1:0]     readY,
  output logic [COLOR_BITS-1:0] color,
  output logic                  colorValid,
  input  logic                  wrEnable,
  input  logic [X_BITS-1:0]     writeX,
  input  logic [Y_BITS-1:0]     writeY,
  input  logic [COLOR_BITS-1:0] writeColor,
  input  logic [1:0]            writeMode,
  input  logic                  clearReq,
  input  logic [COLOR_BITS-1:0] clearColor,
  output logic                  busy,
  output logic                  clearDone
);

  localparam int DEPTH = FRAME_WIDTH * FRAME_HEIGHT;
  localparam logic [ADDR_BITS-1:0] W_A =
    ADDR_BITS'(FRAME_WIDTH);
  localparam logic [ADDR_BITS-1:0] LAST_A =
    ADDR_BITS'(DEPTH - 1);
  localparam logic [X_BITS:0] W_X =
    (X_BITS+1)'(FRAME_WIDTH);
  localparam logic [Y_BITS:0] H_Y =
    (Y_BITS+1)'(FRAME_HEIGHT);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e                state_q;
  logic [ADDR_BITS-1:0]  cnt_q;
  logic [COLOR_BITS-1:0] fill_q;
  logic [COLOR_BITS-1:0] color_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic [COLOR_BITS-1:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0]  raddr;
  logic [ADDR_BITS-1:0]  waddr;
  logic                  rd_in;
  logic                  wr_in;
  logic [COLOR_BITS-1:0] wold;

  logic                  mwe_d;
  logic [ADDR_BITS-1:0]  maddr_d;
  logic [COLOR_BITS-1:0] mdata_d;

  function automatic logic [ADDR_BITS-1:0] lin(
    input logic [X_BITS-1:0] x,
    input logic [Y_BITS-1:0] y
  );
    logic [ADDR_BITS-1:0] xa;
    logic [ADDR_BITS-1:0] ya;
    xa = ADDR_BITS'(x);
    ya = ADDR_BITS'(y);
    return ya * W_A + xa;
  endfunction

  assign raddr = lin(readX, readY);
  assign waddr = lin(writeX, writeY);
  assign rd_in = ({1'b0, readX} < W_X) &&
                 ({1'b0, readY} < H_Y);
  assign wr_in = ({1'b0, writeX} < W_X) &&
                 ({1'b0, writeY} < H_Y);
  assign wold  = mem_q[waddr];

  // The fill owns the write port; user writes are dropped.
  always_comb begin
    mwe_d   = 1'b0;
    maddr_d = waddr;
    mdata_d = '0;
    if (state_q == S_CLEAR) begin
      mwe_d   = 1'b1;
      maddr_d = cnt_q;
      mdata_d = fill_q;
    end else if (wrEnable && wr_in) begin
      mwe_d = 1'b1;
      unique case (writeMode)
        2'b00: mdata_d = writeColor;
        2'b01: mdata_d = wold | writeColor;
        2'b10: mdata_d = '0;
        2'b11: mdata_d = wold ^ writeColor;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetN && mwe_d) begin
      mem_q[maddr_d] <= mdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (clearReq) begin
            fill_q  <= clearColor;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + ADDR_BITS'(1);
          if (cnt_q == LAST_A) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Nonblocking update of mem_q gives read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= readEn;
      if (readEn) begin
        color_q <= rd_in ? mem_q[raddr] : '0;
      end
    end
  end

  assign color      = color_q;
  assign colorValid = valid_q;
  assign busy       = busy_q;
  assign clearDone  = done_q;

endmodule
